// File: rtl/xung_ctrl.sv
// Run-time controller for the pulse/tick generator: programmable divider with IDLE/RUN/PAUSE sequencing.
// Optional one-shot mode is enabled with `define XUNG_CTRL_ONESHOT_EN (adds the oneshot port).
module xung_ctrl #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned DIV_W  = 26,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
`ifdef XUNG_CTRL_ONESHOT_EN
  input  logic             oneshot,
`endif
  output logic             cfg_ready,
  output logic             q,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] tick_cnt
);

  localparam logic [DIV_W-1:0] HALF_RST = DIV_W'(CLK_HZ / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0]   half_div_q, half_div_d;
  logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic               q_q, q_d;
  logic               tick_q, tick_d;
  logic               oneshot_q, oneshot_d;
  logic               oneshot_in;
  logic               wrap;

`ifdef XUNG_CTRL_ONESHOT_EN
  assign oneshot_in = oneshot;
`else
  assign oneshot_in = 1'b0;
`endif

  assign wrap = (div_cnt_q == half_div_q);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    half_div_d = half_div_q;
    tick_cnt_d = tick_cnt_q;
    q_d        = q_q;
    tick_d     = 1'b0;
    oneshot_d  = oneshot_q;
    unique case (state_q)
      S_IDLE: begin
        // Forcing q low here also retires the final high level of a one-shot run.
        q_d       = 1'b0;
        div_cnt_d = '0;
        if (cfg_valid) half_div_d = cfg_div;
        if (start) begin
          state_d    = S_RUN;
          tick_cnt_d = '0;
          oneshot_d  = oneshot_in;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d   = S_IDLE;
          q_d       = 1'b0;
          div_cnt_d = '0;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (wrap) begin
          div_cnt_d = '0;
          q_d       = ~q_q;
          if (!q_q) begin
            tick_d     = 1'b1;
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
            if (oneshot_q) state_d = S_IDLE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d   = S_IDLE;
          q_d       = 1'b0;
          div_cnt_d = '0;
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      half_div_q <= HALF_RST;
      tick_cnt_q <= '0;
      q_q        <= 1'b0;
      tick_q     <= 1'b0;
      oneshot_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      half_div_q <= half_div_d;
      tick_cnt_q <= tick_cnt_d;
      q_q        <= q_d;
      tick_q     <= tick_d;
      oneshot_q  <= oneshot_d;
    end
  end

  assign q         = q_q;
  assign tick      = tick_q;
  assign tick_cnt  = tick_cnt_q;
  assign running   = (state_q == S_RUN);
  assign cfg_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_xung_ctrl.sv
// Self-checking bench for xung_ctrl: per-cycle model comparison plus directed literal checks.
module tb_xung_ctrl;
  localparam int unsigned CLK_HZ = 20;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int          HDEF   = CLK_HZ / 2 - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             pause = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
`ifdef XUNG_CTRL_ONESHOT_EN
  logic             oneshot = 1'b0;
`endif
  logic             cfg_ready;
  logic             q;
  logic             tick;
  logic             running;
  logic [CNT_W-1:0] tick_cnt;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  xung_ctrl #(.CLK_HZ(CLK_HZ), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .pause(pause),
    .cfg_valid(cfg_valid),
    .cfg_div(cfg_div),
`ifdef XUNG_CTRL_ONESHOT_EN
    .oneshot(oneshot),
`endif
    .cfg_ready(cfg_ready),
    .q(q),
    .tick(tick),
    .running(running),
    .tick_cnt(tick_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counts active run cycles since start; toggles happen every (h+1) of them.
  typedef enum {M_IDLE, M_RUN, M_PAUSE} mmode_t;
  mmode_t m_mode = M_IDLE;
  int     m_n = 0;
  int     m_h = HDEF;
  int     m_tc = 0;
  bit     m_q = 1'b0;
  bit     m_tick = 1'b0;
  bit     m_os = 1'b0;

  task automatic model_step();
    int  k;
    bit  os_in;
`ifdef XUNG_CTRL_ONESHOT_EN
    os_in = oneshot;
`else
    os_in = 1'b0;
`endif
    if (rst) begin
      m_mode = M_IDLE; m_n = 0; m_h = HDEF; m_tc = 0;
      m_q = 1'b0; m_tick = 1'b0; m_os = 1'b0;
      return;
    end
    m_tick = 1'b0;
    case (m_mode)
      M_IDLE: begin
        m_q = 1'b0;
        if (cfg_valid) m_h = int'(cfg_div);
        if (start) begin
          m_mode = M_RUN; m_n = 0; m_tc = 0; m_os = os_in;
        end
      end
      M_RUN: begin
        if (stop) begin
          m_mode = M_IDLE; m_q = 1'b0;
        end else if (pause) begin
          m_mode = M_PAUSE;
        end else begin
          m_n++;
          if (m_n % (m_h + 1) == 0) begin
            k   = m_n / (m_h + 1);
            m_q = k[0];
            if (k[0]) begin
              m_tick = 1'b1;
              m_tc   = (m_tc + 1) % (1 << CNT_W);
              if (m_os) m_mode = M_IDLE;
            end
          end
        end
      end
      M_PAUSE: begin
        if (stop) begin
          m_mode = M_IDLE; m_q = 1'b0;
        end else if (start) begin
          m_mode = M_RUN;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  initial begin
    while (!done) begin
      @(posedge clk);
      model_step();
      #1;
      chk("m_q", q, m_q);
      chk("m_tick", tick, m_tick);
      chk("m_running", running, m_mode == M_RUN);
      chk("m_cfg_ready", cfg_ready, m_mode == M_IDLE);
      chk("m_tick_cnt", tick_cnt, m_tc);
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset then idle
    nclk(2);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) nclk(1);
    chk("idle_q", q, 0);
    chk("idle_tick_cnt", tick_cnt, 0);
    chk("idle_cfg_ready", cfg_ready, 1);

    // Programmed rate: cfg_div=3 with start in the same cycle
    cfg_valid = 1'b1; cfg_div = 8'd3; start = 1'b1;
    nclk(1);
    cfg_valid = 1'b0; start = 1'b0;
    chk("run_running", running, 1);
    chk("run_cfg_ready", cfg_ready, 0);
    nclk(3);
    chk("first_tick_early", tick, 0);
    nclk(1);
    chk("first_tick", tick, 1);
    chk("first_q_rise", q, 1);
    chk("first_tick_cnt", tick_cnt, 1);
    nclk(4);
    chk("q_low_half", q, 0);
    nclk(4);
    chk("second_tick", tick, 1);
    nclk(24);
    chk("fifth_tick", tick, 1);
    chk("five_ticks", tick_cnt, 5);

    // Pause at div_cnt=2, hold 10 cycles, resume
    nclk(2);
    pause = 1'b1;
    nclk(1);
    pause = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("pause_q", q, 1);
      chk("pause_tick_cnt", tick_cnt, 5);
      nclk(1);
    end
    start = 1'b1;
    nclk(1);
    start = 1'b0;
    nclk(1);
    chk("resume_q_hold", q, 1);
    nclk(1);
    chk("resume_toggle", q, 0);

    // stop+pause on the wrap cycle
    nclk(3);
    stop = 1'b1; pause = 1'b1;
    nclk(1);
    stop = 1'b0; pause = 1'b0;
    chk("coll_tick", tick, 0);
    chk("coll_q", q, 0);
    chk("coll_cfg_ready", cfg_ready, 1);
    chk("coll_running", running, 0);
    chk("coll_tick_cnt", tick_cnt, 5);

    // cfg_valid during RUN must not change the period
    start = 1'b1;
    nclk(1);
    start = 1'b0;
    cfg_valid = 1'b1; cfg_div = 8'd0;
    nclk(1);
    cfg_valid = 1'b0;
    nclk(3);
    chk("runcfg_tick1", tick, 1);
    nclk(7);
    chk("runcfg_gap", tick, 0);
    nclk(1);
    chk("runcfg_tick2", tick, 1);
    stop = 1'b1;
    nclk(1);
    stop = 1'b0;

    // Wrap with cfg_div=0
    cfg_valid = 1'b1; cfg_div = 8'd0; start = 1'b1;
    nclk(1);
    cfg_valid = 1'b0; start = 1'b0;
    nclk(29);
    chk("wrap_15", tick_cnt, 15);
    nclk(2);
    chk("wrap_0", tick_cnt, 0);
    nclk(2);
    chk("wrap_1", tick_cnt, 1);

    // Reset mid-run, with a competing command
    rst = 1'b1; start = 1'b1;
    nclk(1);
    rst = 1'b0; start = 1'b0;
    chk("rst_q", q, 0);
    chk("rst_tick", tick, 0);
    chk("rst_tick_cnt", tick_cnt, 0);
    chk("rst_running", running, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    start = 1'b1;
    nclk(1);
    start = 1'b0;
    nclk(9);
    chk("default_div_early", tick, 0);
    nclk(1);
    chk("default_div_tick", tick, 1);
    stop = 1'b1;
    nclk(1);
    stop = 1'b0;

`ifdef XUNG_CTRL_ONESHOT_EN
    cfg_valid = 1'b1; cfg_div = 8'd1; start = 1'b1; oneshot = 1'b1;
    nclk(1);
    cfg_valid = 1'b0; start = 1'b0; oneshot = 1'b0;
    nclk(1);
    chk("os_early", tick, 0);
    nclk(1);
    chk("os_tick", tick, 1);
    chk("os_q", q, 1);
    chk("os_running", running, 0);
    chk("os_cfg_ready", cfg_ready, 1);
    nclk(1);
    chk("os_q_low", q, 0);
    chk("os_tick_once", tick, 0);
    nclk(10);
    chk("os_tick_cnt", tick_cnt, 1);
    chk("os_idle", running, 0);
`endif

    nclk(2);
    done = 1'b1;
    nclk(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xung_ctrl.md
# xung_ctrl

Run-time controller for the board's pulse/tick generator: owns a programmable clock divider and sequences it through idle, run and pause. Produces a square wave `q` and a one-cycle `tick` per output period, with the default configuration giving 1 Hz from a 50 MHz `clk`. Sits between user controls (buttons or host registers) and the downstream counter and display logic, replacing the fixed-rate `xung1hz` divider where start, stop, pause or rate changes are needed.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency. Sets the default half-period.
- `DIV_W`, 26: width of the half-period register and the divide counter.
- `CNT_W`, 8: width of `tick_cnt`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle command. IDLE→RUN, or PAUSE→RUN.
- `stop` in 1: single-cycle command. RUN/PAUSE→IDLE.
- `pause` in 1: single-cycle command. RUN→PAUSE.
- `cfg_valid` in 1: a new half-period is offered.
- `cfg_div` in DIV_W: new half-period minus one (`half_div`).
- `cfg_ready` out 1: high only in IDLE. Transfer happens when `cfg_valid`&&`cfg_ready`.
- `q` out 1: registered square wave.
- `tick` out 1: registered pulse, high for 1 cycle per output period.
- `running` out 1: high in RUN.
- `tick_cnt` out CNT_W: number of ticks since the last start-from-IDLE. Wraps.
- `oneshot` in 1: present only with `XUNG_CTRL_ONESHOT_EN`.

## Operation
- State machine has three states: IDLE (reset state), RUN and PAUSE.
- Command priority, when several arrive in the same cycle: stop > pause > start.
- IDLE:
  - `start` → RUN. Clears `div_cnt` to 0, `q` to 0 and `tick_cnt` to 0.
  - `stop` and `pause` are ignored.
- RUN:
  - `div_cnt` increments each cycle.
  - When `div_cnt`==`half_div`: `div_cnt`←0 and `q` toggles.
  - `tick`←1 on the toggle that drives `q` from 0 to 1. `tick` is 0 on all other cycles.
  - `pause` → PAUSE. `div_cnt` and `q` are held.
  - `stop` → IDLE. `q`←0 and `div_cnt`←0.
  - `start` is ignored.
- PAUSE:
  - `tick`=0. `q`, `div_cnt` and `tick_cnt` are frozen.
  - `start` → RUN, resuming from the frozen count.
  - `stop` → IDLE.
  - `pause` is ignored.
- Configuration load:
  - On a transfer, `half_div`←`cfg_div`. All values are legal; 0 makes `q` toggle every cycle.
  - A transfer and `start` in the same IDLE cycle are both honoured, and RUN uses the new `half_div`.
  - `cfg_valid` outside IDLE is not accepted and has no effect.
- `tick_cnt` increments on every tick and wraps from 2^CNT_W−1 to 0.
- Boundary cases:
  - `stop` or `pause` in the cycle where `div_cnt`==`half_div`: the command wins. There is no toggle and no tick.
  - `rst` mid-operation: every register returns to its reset value at that edge, regardless of any command.

## Timing
- Reset values:
  - state IDLE, `q`=0, `tick`=0, `running`=0, `tick_cnt`=0, `div_cnt`=0, `cfg_ready`=1.
  - `half_div`=CLK_HZ/2−1, which is 24_999_999 by default.
- `start` sampled at edge E0:
  - `running`=1 from E0.
  - First `q` rise, with `tick`=1, at edge E0+`half_div`+1.
- Output period is 2·(`half_div`+1) cycles, with 50% duty. The default is 50_000_000 cycles, i.e. 1 s.
- `tick` and the `q` rise appear in the same cycle.
- `tick_cnt` updates on the same edge that raises `tick`.
- `cfg_ready` is decoded from the state with no added latency: it falls the cycle after `start` is accepted.

## Configuration
- `XUNG_CTRL_ONESHOT_EN` defined:
  - The `oneshot` port exists and is sampled together with an accepted IDLE→RUN `start`.
  - If it was 1, then on the edge that produces the first tick the FSM goes to IDLE, `tick` pulses once, and `q` is forced to 0 on the following edge.
- Not defined:
  - The port is absent and the block always free-runs.

## Test plan
- Reset then idle:
  - Hold `rst` 2 cycles, release, wait 100 cycles.
  - Required: `q`=0, `tick`=0, `tick_cnt`=0, `cfg_ready`=1 throughout.
- Programmed rate:
  - Send `cfg_div`=3 with `cfg_valid` and `start` in the same cycle.
  - Required: first tick 4 cycles later, ticks every 8 cycles, `q` high 4 / low 4.
  - Required: `tick_cnt` reads 5 after 5 ticks.
- Pause and resume:
  - With `cfg_div`=3, `pause` at `div_cnt`=2, hold 10 cycles, then `start`.
  - Required: `q` and `tick_cnt` frozen during the pause; next toggle exactly 2 cycles after resume.
- Command collision:
  - `stop`+`pause` in the cycle `div_cnt`==`half_div`.
  - Required: IDLE, no tick, `q`=0, `cfg_ready`=1.
  - Also: `cfg_valid` during RUN leaves the period unchanged.
- Wrap and reset:
  - With CNT_W=4 and `cfg_div`=0, run 17 ticks.
  - Required: `tick_cnt` goes 15→0→1.
  - Then assert `rst` mid-period. Required: all outputs at reset values on the next edge, and `half_div` restored to its default.
- One-shot, with `XUNG_CTRL_ONESHOT_EN`:
  - `start`+`oneshot` with `cfg_div`=1.
  - Required: exactly one tick 2 cycles later, then IDLE, `running`=0.
